// File: rtl/asic_readback_rx_pkg.sv
// Shared constants and FSM encoding for the ASIC readback receiver.
// Frame sizes match the config writer; state enum used by the receiver FSM.
package asic_readback_rx_pkg;

    localparam int DEF_SIZESRSTAT = 88;
    localparam int DEF_SIZESRDYN  = 16;
    localparam int DEF_CNTW       = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } rb_state_e;

endpackage

// File: rtl/asic_readback_rx_sync_2ff.sv
// Single-bit two-flop synchroniser into the system clock domain.
// Ports: clk_i, rst_i (async active-high, clears to 0), d_i async input, q_o synced.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/asic_readback_rx.sv
// Captures the MISO readback frame, rebuilds static/dynamic images, compares to written values.
// Ports: CLK/RST, async sclk_in/sel_in/miso_input, expected images in; rb images, pulses, mismatch, busy out.
module asic_readback_rx
    import asic_readback_rx_pkg::*;
#(
    parameter int SIZESRSTAT = DEF_SIZESRSTAT,
    parameter int SIZESRDYN  = DEF_SIZESRDYN,
    parameter int CNTW       = DEF_CNTW
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  sclk_in,
    input  logic                  sel_in,
    input  logic                  miso_input,
    input  logic [SIZESRSTAT-1:0] static_conf_ear,
    input  logic [SIZESRDYN-1:0]  dynamic_conf,
    output logic [SIZESRSTAT-1:0] stat_rb,
    output logic [SIZESRDYN-1:0]  dyn_rb,
    output logic                  stat_valid,
    output logic                  dyn_valid,
    output logic                  stat_mismatch,
    output logic                  dyn_mismatch,
    output logic                  frame_err,
    output logic                  busy
);

    localparam logic [CNTW-1:0] CNT_STAT = CNTW'(SIZESRSTAT);
    localparam logic [CNTW-1:0] CNT_DYN  = CNTW'(SIZESRDYN);
    localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(SIZESRSTAT + 1);

    logic sclk_s;
    logic sel_s;
    logic miso_s;

    sync_2ff u_sync_sclk (.clk_i(CLK), .rst_i(RST), .d_i(sclk_in),    .q_o(sclk_s));
    sync_2ff u_sync_sel  (.clk_i(CLK), .rst_i(RST), .d_i(sel_in),     .q_o(sel_s));
    sync_2ff u_sync_miso (.clk_i(CLK), .rst_i(RST), .d_i(miso_input), .q_o(miso_s));

    rb_state_e             state_q, state_d;
    logic                  sclk_d_q;
    logic [SIZESRSTAT-1:0] sr_q;
    logic [CNTW-1:0]       cnt_q;
    logic                  sclk_rise;

    // MISO shares the SCLK sync delay, so miso_s is the pin value at the edge.
    assign sclk_rise = sclk_s & ~sclk_d_q;
    assign busy      = (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (sel_s)  state_d = ST_SHIFT;
            ST_SHIFT: if (!sel_s) state_d = ST_LATCH;
            ST_LATCH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            sclk_d_q <= 1'b0;
            sr_q     <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sclk_d_q <= sclk_s;
            if (state_q == ST_IDLE && sel_s) begin
                cnt_q <= '0;
            end
            // A rise coinciding with the SEL drop is still shifted.
            if (state_q == ST_SHIFT && sclk_rise) begin
                sr_q <= {sr_q[SIZESRSTAT-2:0], miso_s};
                if (cnt_q != CNT_MAX) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stat_rb       <= '0;
            dyn_rb        <= '0;
            stat_valid    <= 1'b0;
            dyn_valid     <= 1'b0;
            stat_mismatch <= 1'b0;
            dyn_mismatch  <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            stat_valid <= 1'b0;
            dyn_valid  <= 1'b0;
            frame_err  <= 1'b0;
            if (state_q == ST_LATCH) begin
                if (cnt_q == CNT_STAT) begin
                    stat_rb       <= sr_q;
                    stat_valid    <= 1'b1;
                    stat_mismatch <= (sr_q != static_conf_ear);
                end else if (cnt_q == CNT_DYN) begin
                    dyn_rb       <= sr_q[SIZESRDYN-1:0];
                    dyn_valid    <= 1'b1;
                    dyn_mismatch <= (sr_q[SIZESRDYN-1:0] != dynamic_conf);
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_asic_readback_rx.sv
// Directed bench for asic_readback_rx: vector table plus hand-written corner sequences.
// SCLK runs at CLK/8; outputs sampled on the falling CLK edge.
module tb_asic_readback_rx;

    logic         CLK = 1'b0;
    logic         RST;
    logic         sclk_in;
    logic         sel_in;
    logic         miso_input;
    logic [87:0]  static_conf_ear;
    logic [15:0]  dynamic_conf;
    logic [87:0]  stat_rb;
    logic [15:0]  dyn_rb;
    logic         stat_valid;
    logic         dyn_valid;
    logic         stat_mismatch;
    logic         dyn_mismatch;
    logic         frame_err;
    logic         busy;

    asic_readback_rx dut (
        .CLK(CLK), .RST(RST),
        .sclk_in(sclk_in), .sel_in(sel_in), .miso_input(miso_input),
        .static_conf_ear(static_conf_ear), .dynamic_conf(dynamic_conf),
        .stat_rb(stat_rb), .dyn_rb(dyn_rb),
        .stat_valid(stat_valid), .dyn_valid(dyn_valid),
        .stat_mismatch(stat_mismatch), .dyn_mismatch(dyn_mismatch),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    int n_stat = 0, n_dyn = 0, n_err = 0;
    int last_stat = 0, last_dyn = 0, last_err = 0;
    int vecs = 0, errs = 0;

    always @(posedge CLK) cyc++;

    always @(negedge CLK) begin
        if (stat_valid) begin n_stat++; last_stat = cyc; end
        if (dyn_valid)  begin n_dyn++;  last_dyn  = cyc; end
        if (frame_err)  begin n_err++;  last_err  = cyc; end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send(input int nbits, input logic [127:0] data, output int fall);
        @(negedge CLK);
        sel_in  = 1'b1;
        sclk_in = 1'b0;
        wait_clk(4);
        for (int i = nbits - 1; i >= 0; i--) begin
            miso_input = data[i];
            wait_clk(4);
            sclk_in = 1'b1;
            wait_clk(4);
            sclk_in = 1'b0;
        end
        wait_clk(4);
        sel_in = 1'b0;
        fall   = cyc;
    endtask

    function automatic logic lat_ok(input int lat);
        return (lat == 4 || lat == 5);
    endfunction

    typedef struct {
        int            nbits;
        logic [127:0]  data;
        logic [87:0]   exp_s;
        logic [15:0]   exp_d;
        int            kind;
        logic [87:0]   srb;
        logic [15:0]   drb;
        logic          smis;
        logic          dmis;
    } vec_t;

    localparam logic [87:0] P = {11{8'hA5}};

    vec_t tbl[6];

    initial begin
        int fall, fall2, ps, pd, pe, lat;

        RST = 1'b1; sclk_in = 1'b0; sel_in = 1'b0; miso_input = 1'b0;
        static_conf_ear = '0; dynamic_conf = '0;

        tbl[0] = '{88,  {40'd0, P},                  P,           16'h0000, 0, P, 16'h0000, 1'b0, 1'b0};
        tbl[1] = '{16,  128'h1234,                   P,           16'h1235, 1, P, 16'h1234, 1'b0, 1'b1};
        tbl[2] = '{40,  128'hFF_0000_1111,           P,           16'h1235, 2, P, 16'h1234, 1'b0, 1'b1};
        tbl[3] = '{100, 128'h0123_4567_89AB_CDEF_0F1E_2D3C, P,    16'h1235, 2, P, 16'h1234, 1'b0, 1'b1};
        tbl[4] = '{88,  {40'd0, P},                  P ^ 88'h1,   16'h1235, 0, P, 16'h1234, 1'b1, 1'b1};
        tbl[5] = '{16,  128'h1235,                   P,           16'h1235, 1, P, 16'h1235, 1'b1, 1'b0};

        wait_clk(3);
        chk("rst_busy",  128'(busy), 128'(0));
        chk("rst_pulses", 128'({stat_valid, dyn_valid, frame_err}), 128'(0));
        RST = 1'b0;
        wait_clk(2);
        chk("rst_stat_rb", 128'(stat_rb), 128'(0));
        chk("rst_dyn_rb",  128'(dyn_rb),  128'(0));
        chk("rst_mis", 128'({stat_mismatch, dyn_mismatch}), 128'(0));

        for (int v = 0; v < 6; v++) begin
            static_conf_ear = tbl[v].exp_s;
            dynamic_conf    = tbl[v].exp_d;
            ps = n_stat; pd = n_dyn; pe = n_err;
            send(tbl[v].nbits, tbl[v].data, fall);
            wait_clk(10);
            chk($sformatf("v%0d_stat_pulses", v), 128'(n_stat - ps), 128'(tbl[v].kind == 0));
            chk($sformatf("v%0d_dyn_pulses", v),  128'(n_dyn - pd),  128'(tbl[v].kind == 1));
            chk($sformatf("v%0d_err_pulses", v),  128'(n_err - pe),  128'(tbl[v].kind == 2));
            lat = (tbl[v].kind == 0) ? last_stat - fall :
                  (tbl[v].kind == 1) ? last_dyn - fall : last_err - fall;
            chk($sformatf("v%0d_latency_ok(%0d)", v, lat), 128'(lat_ok(lat)), 128'(1));
            chk($sformatf("v%0d_stat_rb", v), 128'(stat_rb), 128'(tbl[v].srb));
            chk($sformatf("v%0d_dyn_rb", v),  128'(dyn_rb),  128'(tbl[v].drb));
            chk($sformatf("v%0d_stat_mis", v), 128'(stat_mismatch), 128'(tbl[v].smis));
            chk($sformatf("v%0d_dyn_mis", v),  128'(dyn_mismatch),  128'(tbl[v].dmis));
        end

        // Zero-bit frame: SEL high for 10 CLK, no SCLK.
        ps = n_stat; pd = n_dyn; pe = n_err;
        @(negedge CLK);
        sel_in = 1'b1;
        wait_clk(5);
        chk("zero_busy", 128'(busy), 128'(1));
        wait_clk(5);
        sel_in = 1'b0;
        wait_clk(10);
        chk("zero_err",   128'(n_err - pe),  128'(1));
        chk("zero_valid", 128'((n_stat - ps) + (n_dyn - pd)), 128'(0));
        chk("zero_idle",  128'(busy), 128'(0));

        // Reset after 30 bits of a static frame, then a clean dynamic frame.
        ps = n_stat; pd = n_dyn; pe = n_err;
        @(negedge CLK);
        sel_in = 1'b1;
        wait_clk(4);
        for (int i = 87; i > 57; i--) begin
            miso_input = P[i];
            wait_clk(4);
            sclk_in = 1'b1;
            wait_clk(4);
            sclk_in = 1'b0;
        end
        RST = 1'b1;
        wait_clk(2);
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_stat_rb", 128'(stat_rb), 128'(0));
        sel_in = 1'b0;
        wait_clk(3);
        RST = 1'b0;
        wait_clk(10);
        chk("abort_no_pulse", 128'((n_stat - ps) + (n_dyn - pd) + (n_err - pe)), 128'(0));
        dynamic_conf = 16'hBEEF;
        send(16, 128'hBEEF, fall);
        wait_clk(10);
        chk("abort_dyn_pulse", 128'(n_dyn - pd), 128'(1));
        chk("abort_stat_pulse", 128'(n_stat - ps), 128'(0));
        chk("abort_dyn_rb", 128'(dyn_rb), 128'(16'hBEEF));
        chk("abort_dyn_mis", 128'(dyn_mismatch), 128'(0));

        // Back-to-back: SEL low 5 CLK between static and dynamic frames.
        ps = n_stat; pd = n_dyn;
        static_conf_ear = P;
        dynamic_conf    = 16'h5AC3;
        send(88, {40'd0, P}, fall);
        wait_clk(4);
        send(16, 128'h5AC3, fall2);
        wait_clk(10);
        chk("b2b_stat_pulse", 128'(n_stat - ps), 128'(1));
        chk("b2b_dyn_pulse",  128'(n_dyn - pd),  128'(1));
        lat = last_stat - fall;
        chk($sformatf("b2b_stat_lat(%0d)", lat), 128'(lat_ok(lat)), 128'(1));
        lat = last_dyn - fall2;
        chk($sformatf("b2b_dyn_lat(%0d)", lat), 128'(lat_ok(lat)), 128'(1));
        chk("b2b_stat_rb", 128'(stat_rb), 128'(P));
        chk("b2b_dyn_rb",  128'(dyn_rb),  128'(16'h5AC3));
        chk("b2b_mis", 128'({stat_mismatch, dyn_mismatch}), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
